// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame width, default divider
// and the operand-select encodings that the ID stage decodes from uart_flag.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int UART_DATA_BITS   = 8;
    localparam int DEFAULT_BAUD_DIV = 5208;

    localparam logic OP1_SEL = 1'b0;
    localparam logic OP2_SEL = 1'b1;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-to-ID bundle. The receiver drives it (master) and the ID stage
// consumes it (slave); uart_rx_data is only meaningful while uart_signal is high.
interface uart_rx_ctrl_if;
    import uart_pkg::*;

    logic                      uart_signal;
    logic                      uart_flag;
    logic [UART_DATA_BITS-1:0] uart_rx_data;
    logic                      frame_err;
    logic                      rx_busy;

    modport master (
        output uart_signal,
        output uart_flag,
        output uart_rx_data,
        output frame_err,
        output rx_busy
    );

    modport slave (
        input uart_signal,
        input uart_flag,
        input uart_rx_data,
        input frame_err,
        input rx_busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input. RESET_VAL lets the
// flops come out of reset at the line's idle level so no false edge is seen.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first one a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver that hands each good byte to the ID stage as a one-cycle
// strobe and alternates the destination operand select on every accepted byte.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           uart_rx,
    uart_rx_ctrl_if.master rx_if
);

    // Start is sampled half a bit in; data and stop a full bit after the previous sample.
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);

    rx_state_t                 state;
    rx_state_t                 next_state;
    logic                      rxs;
    logic [15:0]               cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      shift_en;
    logic                      strobe_set;
    logic                      err_set;
    logic                      sig_q;
    logic                      err_q;
    logic                      flag_q;
    logic [UART_DATA_BITS-1:0] data_q;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rx),
        .q     (rxs)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the one-cycle shift / strobe / error requests.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        strobe_set = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    next_state = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    next_state = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    if (rxs) begin
                        strobe_set = 1'b1;
                        next_state = IDLE;
                    end else begin
                        err_set    = 1'b1;
                        next_state = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxs) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Baud counter wraps each bit period and restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (next_state != state || cnt == BIT_LAST) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Bit index and LSB-first shift register; the index restarts on entry to DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= 3'd0;
            shreg   <= '0;
        end else begin
            if (next_state == DATA && state != DATA) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shreg <= {rxs, shreg[UART_DATA_BITS-1:1]};
            end
        end
    end

    // Registered outputs; the operand select flips only after its strobe has been seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q  <= 1'b0;
            err_q  <= 1'b0;
            flag_q <= OP1_SEL;
            data_q <= '0;
        end else begin
            sig_q <= strobe_set;
            err_q <= err_set;
            if (strobe_set) begin
                data_q <= shreg;
            end
            if (sig_q) begin
                flag_q <= ~flag_q;
            end
        end
    end

    assign rx_if.uart_signal  = sig_q;
    assign rx_if.frame_err    = err_q;
    assign rx_if.uart_flag    = flag_q;
    assign rx_if.uart_rx_data = data_q;
    assign rx_if.rx_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a divide-by-16 instance for the main scenarios and a
// divide-by-5 instance for the odd-divider case, checked against a frame-level model.
module tb_uart_rx_ctrl;

    typedef struct {
        int         inst;
        int         cyc;
        logic       good;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        int         inst;
        int         cyc;
        logic [7:0] data;
        logic       flag;
    } log_t;

    logic clk;
    logic rst_n;
    logic line [2];
    int   cyc;
    int   checks;
    int   failures;
    int   err_count;

    ev_t  exp_q [$];
    log_t slog [$];
    int   starts [$];

    logic [7:0] m_data [2];
    logic       m_flag [2];

    logic       a_sig  [2];
    logic       a_err  [2];
    logic       a_flag [2];
    logic       a_busy [2];
    logic [7:0] a_data [2];

    uart_rx_ctrl_if bus16 ();
    uart_rx_ctrl_if bus5 ();

    uart_rx_ctrl #(.BAUD_DIV(16)) dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (line[0]),
        .rx_if   (bus16)
    );

    uart_rx_ctrl #(.BAUD_DIV(5)) dut5 (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (line[1]),
        .rx_if   (bus5)
    );

    assign a_sig[0]  = bus16.uart_signal;
    assign a_err[0]  = bus16.frame_err;
    assign a_flag[0] = bus16.uart_flag;
    assign a_busy[0] = bus16.rx_busy;
    assign a_data[0] = bus16.uart_rx_data;
    assign a_sig[1]  = bus5.uart_signal;
    assign a_err[1]  = bus5.frame_err;
    assign a_flag[1] = bus5.uart_flag;
    assign a_busy[1] = bus5.rx_busy;
    assign a_data[1] = bus5.uart_rx_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp: value seen at a negedge equals the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bd_of(input int i);
        return (i == 0) ? 16 : 5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at cyc %0d", name, act, req, cyc);
        end
    endtask

    // Frame-level model comparison on every falling edge, for both instances.
    always @(negedge clk) begin
        logic e_sig;
        logic e_err;
        for (int i = 0; i < 2; i++) begin
            e_sig = 1'b0;
            e_err = 1'b0;
            if (!rst_n) begin
                checkOutput("reset_signal", a_sig[i], 1'b0);
                checkOutput("reset_err",    a_err[i], 1'b0);
                checkOutput("reset_flag",   a_flag[i], 1'b0);
                checkOutput("reset_data",   a_data[i], 8'h00);
                checkOutput("reset_busy",   a_busy[i], 1'b0);
            end else begin
                for (int k = exp_q.size() - 1; k >= 0; k--) begin
                    if (exp_q[k].inst == i) begin
                        if (exp_q[k].cyc == cyc) begin
                            if (exp_q[k].good) begin
                                e_sig     = 1'b1;
                                m_data[i] = exp_q[k].data;
                            end else begin
                                e_err = 1'b1;
                            end
                            exp_q.delete(k);
                        end else if (exp_q[k].cyc < cyc) begin
                            checks++;
                            failures++;
                            $display("[TB] FAIL missed_event inst=%0d actual=none required=cyc %0d", i, exp_q[k].cyc);
                            exp_q.delete(k);
                        end
                    end
                end
                checkOutput("uart_signal",  a_sig[i],  e_sig);
                checkOutput("frame_err",    a_err[i],  e_err);
                checkOutput("uart_rx_data", a_data[i], m_data[i]);
                checkOutput("uart_flag",    a_flag[i], m_flag[i]);
                if (a_sig[i]) begin
                    slog.push_back('{inst: i, cyc: cyc, data: a_data[i], flag: a_flag[i]});
                end
                if (a_err[i]) begin
                    err_count++;
                end
                if (e_sig) begin
                    m_flag[i] = ~m_flag[i];
                end
            end
        end
    end

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        line[0] = 1'b1;
        line[1] = 1'b1;
        exp_q.delete();
        slog.delete();
        starts.delete();
        err_count = 0;
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 8'h00;
            m_flag[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    // Drives one frame; the strobe is due BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles after
    // the synchronised start, which is 2 edges after the pin drive, stamped +1 at negedge.
    task automatic applyStimulus(input int i, input logic [7:0] b, input logic stop, input int abort_bit);
        int  bd;
        int  n;
        ev_t ev;
        bd = bd_of(i);
        @(posedge clk);
        #1;
        n       = cyc;
        line[i] = 1'b0;
        starts.push_back(n);
        ev.inst = i;
        ev.cyc  = n + 3 + bd / 2 + 9 * bd;
        ev.good = stop;
        ev.data = b;
        exp_q.push_back(ev);
        for (int k = 0; k < 8; k++) begin
            repeat (bd) @(posedge clk);
            #1;
            line[i] = b[k];
            if (k == abort_bit) begin
                repeat (bd / 2) @(posedge clk);
                return;
            end
        end
        repeat (bd) @(posedge clk);
        #1;
        line[i] = stop;
        repeat (bd - 1) @(posedge clk);
    endtask

    task automatic idleBits(input int i, input int n);
        repeat (n * bd_of(i)) @(posedge clk);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        line[0]   = 1'b1;
        line[1]   = 1'b1;
        checks    = 0;
        failures  = 0;
        err_count = 0;
        cyc       = 0;

        // Three frames with one idle bit between them.
        applyReset();
        applyStimulus(0, 8'h35, 1'b1, -1);
        idleBits(0, 1);
        applyStimulus(0, 8'hA7, 1'b1, -1);
        idleBits(0, 1);
        applyStimulus(0, 8'h00, 1'b1, -1);
        idleBits(0, 3);
        checkOutput("t1_count",  slog.size(), 3);
        checkOutput("t1_d0",     slog[0].data, 8'h35);
        checkOutput("t1_f0",     slog[0].flag, 1'b0);
        checkOutput("t1_d1",     slog[1].data, 8'hA7);
        checkOutput("t1_f1",     slog[1].flag, 1'b1);
        checkOutput("t1_d2",     slog[2].data, 8'h00);
        checkOutput("t1_f2",     slog[2].flag, 1'b0);
        checkOutput("t1_lat",    slog[0].cyc - starts[0], 155);
        checkOutput("t1_errs",   err_count, 0);
        checkOutput("t1_flagend", bus16.uart_flag, 1'b1);

        // Short glitch on an idle line.
        applyReset();
        @(posedge clk);
        #1;
        line[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        line[0] = 1'b1;
        @(negedge clk);
        checkOutput("t2_busy_glitch", bus16.rx_busy, 1'b1);
        repeat (200) @(posedge clk);
        @(negedge clk);
        checkOutput("t2_busy_end", bus16.rx_busy, 1'b0);
        checkOutput("t2_strobes",  slog.size(), 0);
        checkOutput("t2_errs",     err_count, 0);

        // Stop bit low, line held low, then a good frame.
        applyReset();
        applyStimulus(0, 8'hFF, 1'b0, -1);
        repeat (48) @(posedge clk);
        @(negedge clk);
        checkOutput("t3_busy_held", bus16.rx_busy, 1'b1);
        @(posedge clk);
        #1;
        line[0] = 1'b1;
        idleBits(0, 2);
        checkOutput("t3_errs",    err_count, 1);
        checkOutput("t3_nostrobe", slog.size(), 0);
        applyStimulus(0, 8'h12, 1'b1, -1);
        idleBits(0, 2);
        checkOutput("t3_count", slog.size(), 1);
        checkOutput("t3_data",  slog[0].data, 8'h12);
        checkOutput("t3_flag",  slog[0].flag, 1'b0);

        // Back-to-back frames with no idle gap.
        applyReset();
        applyStimulus(0, 8'h55, 1'b1, -1);
        applyStimulus(0, 8'hAA, 1'b1, -1);
        idleBits(0, 2);
        checkOutput("t4_count", slog.size(), 2);
        checkOutput("t4_d0",    slog[0].data, 8'h55);
        checkOutput("t4_f0",    slog[0].flag, 1'b0);
        checkOutput("t4_d1",    slog[1].data, 8'hAA);
        checkOutput("t4_f1",    slog[1].flag, 1'b1);
        checkOutput("t4_lat0",  slog[0].cyc - starts[0], 155);
        checkOutput("t4_lat1",  slog[1].cyc - starts[1], 155);

        // Reset during bit 4 of a frame after one accepted byte.
        applyReset();
        applyStimulus(0, 8'h5A, 1'b1, -1);
        idleBits(0, 1);
        checkOutput("t5_flag_pre", bus16.uart_flag, 1'b1);
        applyStimulus(0, 8'h3C, 1'b1, 4);
        applyReset();
        checkOutput("t5_flag_post", bus16.uart_flag, 1'b0);
        checkOutput("t5_data_post", bus16.uart_rx_data, 8'h00);
        idleBits(0, 2);
        checkOutput("t5_partial", slog.size(), 0);
        applyStimulus(0, 8'h81, 1'b1, -1);
        idleBits(0, 2);
        checkOutput("t5_count", slog.size(), 1);
        checkOutput("t5_data",  slog[0].data, 8'h81);
        checkOutput("t5_flag",  slog[0].flag, 1'b0);

        // Odd divider on the divide-by-5 instance.
        applyReset();
        applyStimulus(1, 8'hC3, 1'b1, -1);
        idleBits(1, 3);
        checkOutput("t6_count", slog.size(), 1);
        checkOutput("t6_inst",  slog[0].inst, 1);
        checkOutput("t6_data",  slog[0].data, 8'hC3);
        checkOutput("t6_flag",  slog[0].flag, 1'b0);
        checkOutput("t6_lat",   slog[0].cyc - starts[0], 50);

        repeat (20) @(posedge clk);
        n = exp_q.size();
        checkOutput("pending_events", n, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
